// File: rtl/frame_write_dma_if.sv
// Bus bundle for frame_write_dma: register-slave control, show-ahead FIFO
// read side and the Avalon-MM burst write master.
interface frame_write_dma_if #(
  parameter int DATA_W  = 32,
  parameter int USEDW_W = 9,
  parameter int BC_W    = 5
);
  logic                control_go;
  logic [31:0]         control_user_base;
  logic [31:0]         control_user_length;
  logic [1:0]          control_en;
  logic                control_state;
  logic                control_done;

  logic [DATA_W-1:0]   fifo_q;
  logic [USEDW_W-1:0]  fifo_usedw;
  logic                fifo_rdreq;

  logic [31:0]         avm_address;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [BC_W-1:0]     avm_burstcount;
  logic                avm_waitrequest;

  modport master (
    input  control_go, control_user_base, control_user_length, control_en,
    output control_state, control_done,
    input  fifo_q, fifo_usedw,
    output fifo_rdreq,
    output avm_address, avm_write, avm_writedata, avm_burstcount,
    input  avm_waitrequest
  );

  modport slave (
    output control_go, control_user_base, control_user_length, control_en,
    input  control_state, control_done,
    output fifo_q, fifo_usedw,
    input  fifo_rdreq,
    input  avm_address, avm_write, avm_writedata, avm_burstcount,
    output avm_waitrequest
  );
endinterface

// File: rtl/frame_write_dma.sv
// Avalon-MM burst write sequencer: drains a show-ahead FIFO to memory in
// length-bounded bursts after a go pulse, optionally looping over the buffer.
module frame_write_dma #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int USEDW_W   = 9,
  parameter int BC_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  frame_write_dma_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST} state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      addr_q, addr_d;
  logic [29:0]      words_q, words_d;
  logic [29:0]      remaining_q, remaining_d;
  logic             loop_q, loop_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0]      avm_address_q, avm_address_d;
  logic [BC_W-1:0]  avm_burstcount_q, avm_burstcount_d;
  logic             avm_write_q, avm_write_d;
  logic             control_state_q, control_state_d;
  logic             control_done_q, control_done_d;

  logic [29:0]      go_words;
  logic [BC_W-1:0]  bc;
  logic             accept;

  assign go_words = bus.control_user_length[31:2];
  assign accept   = avm_write_q & ~bus.avm_waitrequest;
  assign bc       = (remaining_q >= 30'(BURST_MAX)) ? BC_W'(BURST_MAX)
                                                    : remaining_q[BC_W-1:0];

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    addr_d           = addr_q;
    words_d          = words_q;
    remaining_d      = remaining_q;
    loop_d           = loop_q;
    beat_cnt_d       = beat_cnt_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    avm_write_d      = avm_write_q;
    control_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.control_go && bus.control_en[0]) begin
          if (go_words != '0) begin
            base_d      = {bus.control_user_base[31:2], 2'b00};
            addr_d      = {bus.control_user_base[31:2], 2'b00};
            words_d     = go_words;
            remaining_d = go_words;
            loop_d      = bus.control_en[1];
            state_d     = WAIT_DATA;
          end else begin
            control_done_d = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        // Enable is only honoured between bursts; a started burst always finishes.
        if (!bus.control_en[0]) begin
          state_d = IDLE;
        end else if (32'(bus.fifo_usedw) >= 32'(bc)) begin
          avm_address_d    = addr_q;
          avm_burstcount_d = bc;
          beat_cnt_d       = bc;
          avm_write_d      = 1'b1;
          state_d          = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d  = beat_cnt_q - BC_W'(1);
          remaining_d = remaining_q - 30'd1;
          if (beat_cnt_q == BC_W'(1)) begin
            avm_write_d = 1'b0;
            addr_d      = addr_q + 32'({avm_burstcount_q, 2'b00});
            if (remaining_q == 30'd1) begin
              control_done_d = 1'b1;
              if (loop_q && bus.control_en[0]) begin
                addr_d      = base_q;
                remaining_d = words_q;
                state_d     = WAIT_DATA;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    control_state_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      base_q           <= '0;
      addr_q           <= '0;
      words_q          <= '0;
      remaining_q      <= '0;
      loop_q           <= 1'b0;
      beat_cnt_q       <= '0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_write_q      <= 1'b0;
      control_state_q  <= 1'b0;
      control_done_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      addr_q           <= addr_d;
      words_q          <= words_d;
      remaining_q      <= remaining_d;
      loop_q           <= loop_d;
      beat_cnt_q       <= beat_cnt_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      avm_write_q      <= avm_write_d;
      control_state_q  <= control_state_d;
      control_done_q   <= control_done_d;
    end
  end

  assign bus.control_state  = control_state_q;
  assign bus.control_done   = control_done_q;
  assign bus.fifo_rdreq     = accept;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_burstcount = avm_burstcount_q;
  assign bus.avm_writedata  = bus.fifo_q;

endmodule

// File: tb/tb_frame_write_dma.sv
// Bench for frame_write_dma: FIFO and Avalon slave models, expected burst list
// built from transfer parameters, random and directed transfers.
module tb_frame_write_dma;
  localparam int DATA_W = 32, BURST_MAX = 16, USEDW_W = 9, BC_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_write_dma_if #(.DATA_W(DATA_W), .USEDW_W(USEDW_W), .BC_W(BC_W)) bus ();
  frame_write_dma #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .USEDW_W(USEDW_W), .BC_W(BC_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] addr; int bc; bit last; } burst_t;

  int n_tests = 0, n_fail = 0;
  burst_t exp_b[$];
  logic [31:0] hist[$];
  logic [31:0] fq[$];
  int b_idx = 0, rd_idx = 0;
  int push_req = 0, push_done = 0;
  int beats_seen = 0, rdreq_cnt = 0, wr_cycles = 0, done_cnt = 0;
  int wait_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: pop on rdreq, at most one push per cycle
  logic [31:0] w;
  initial begin
    bus.fifo_q = '0;
    bus.fifo_usedw = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        fq.delete();
        push_done = push_req;
      end else begin
        if (bus.fifo_rdreq && fq.size() != 0) void'(fq.pop_front());
        if (push_done != push_req) begin
          w = $urandom;
          fq.push_back(w);
          hist.push_back(w);
          push_done++;
        end
      end
      bus.fifo_q     <= (fq.size() != 0) ? fq[0] : 32'h0;
      bus.fifo_usedw <= USEDW_W'(fq.size());
    end
  end

  // Bus monitor and scoreboard
  burst_t cur;
  int left = 0;
  bit in_burst = 0, done_due = 0, gap = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_burst = 0; done_due = 0; gap = 0;
        b_idx = exp_b.size();
        rd_idx = hist.size();
      end else begin
        chk("done", bus.control_done, done_due);
        done_due = 0;
        if (bus.control_done) done_cnt++;
        chk("rdreq", bus.fifo_rdreq, bus.avm_write & ~bus.avm_waitrequest);
        if (bus.fifo_rdreq) rdreq_cnt++;
        if (gap) chk("gap", bus.avm_write, 0);
        gap = 0;
        if (bus.avm_write) begin
          wr_cycles++;
          if (!in_burst) begin
            if (b_idx < exp_b.size()) begin
              cur = exp_b[b_idx];
              b_idx++;
              left = cur.bc;
              in_burst = 1;
            end else chk("extra_burst", 1, 0);
          end
          if (in_burst) begin
            chk("addr", bus.avm_address, cur.addr);
            chk("bcnt", bus.avm_burstcount, cur.bc);
            chk("data", bus.avm_writedata,
                (rd_idx < hist.size()) ? {32'h0, hist[rd_idx]} : 64'hDEAD_0000_0000_0000);
            if (!bus.avm_waitrequest) begin
              rd_idx++;
              beats_seen++;
              left--;
              if (left == 0) begin
                in_burst = 0;
                gap = 1;
                if (cur.last) done_due = 1;
              end
            end
          end
        end
        // zero-length go is only issued while idle
        if (bus.control_go && bus.control_en[0] && bus.control_user_length[31:2] == 30'd0)
          done_due = 1;
      end
    end
  end

  task automatic add_xfer(input logic [31:0] base, input logic [31:0] len);
    logic [31:0] a;
    int rem, n;
    a = base & 32'hFFFF_FFFC;
    rem = int'(len >> 2);
    while (rem > 0) begin
      n = (rem > BURST_MAX) ? BURST_MAX : rem;
      rem -= n;
      exp_b.push_back('{addr: a, bc: n, last: (rem == 0)});
      a = a + 32'(n * 4);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wait_mode == 1) bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
    else if (wait_mode == 0) bus.avm_waitrequest = 1'b0;
  endtask

  task automatic push(input int n);
    push_req += n;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input logic [1:0] en,
                    input bit expect_xfer);
    bus.control_user_base = base;
    bus.control_user_length = len;
    bus.control_en = en;
    bus.control_go = 1'b1;
    if (expect_xfer) add_xfer(base, len);
    tick();
    bus.control_go = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.control_go = 1'b0;
    bus.control_en = 2'b00;
    wait_mode = 0;
    bus.avm_waitrequest = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_state", bus.control_state, 0);
    chk("rst_done", bus.control_done, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_rdreq", bus.fifo_rdreq, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_bcnt", bus.avm_burstcount, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_fill(input int n);
    int k = 0;
    while (int'(bus.fifo_usedw) < n && k < 300) begin tick(); k++; end
    chk("fill_timeout", k < 300, 1);
  endtask

  task automatic wait_beats(input int target);
    int k = 0;
    while (beats_seen < target && k < 500) begin tick(); k++; end
    chk("beat_timeout", k < 500, 1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (n < max && !(bus.control_state == 1'b0 && b_idx == exp_b.size())) begin
      tick(); n++;
    end
    chk(tag, n < max, 1);
    repeat (2) tick();
  endtask

  int b0, r0, d0, wc0, k, words;
  logic [31:0] rbase, rlen;

  initial begin
    bus.control_go = 1'b0;
    bus.control_user_base = '0;
    bus.control_user_length = '0;
    bus.control_en = 2'b00;
    bus.avm_waitrequest = 1'b0;

    // single burst with exact cycle timing
    do_reset();
    push(64); wait_fill(64);
    d0 = done_cnt;
    go(32'h2000_0000, 32'd64, 2'b01, 1);
    @(negedge clk);
    chk("t1_busy", bus.control_state, 1);
    chk("t1_nowrite", bus.avm_write, 0);
    @(negedge clk);
    chk("t1_write", bus.avm_write, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t1_beats", bus.avm_write, 1);
    end
    @(negedge clk);
    chk("t1_end_write", bus.avm_write, 0);
    chk("t1_end_state", bus.control_state, 0);
    wait_idle("t1_idle", 50);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // split bursts
    do_reset();
    push(25); wait_fill(25);
    r0 = rdreq_cnt; d0 = done_cnt;
    go(32'h0000_1000, 32'd100, 2'b01, 1);
    wait_idle("split_idle", 200);
    chk("split_rdreq", rdreq_cnt - r0, 25);
    chk("split_done", done_cnt - d0, 1);

    // waitrequest stalls inside a 16-beat burst
    do_reset();
    push(16); wait_fill(16);
    b0 = beats_seen;
    go(32'h4000_0000, 32'd64, 2'b01, 1);
    wait_mode = 2;
    wait_beats(b0 + 2);
    bus.avm_waitrequest = 1'b1; repeat (3) tick(); bus.avm_waitrequest = 1'b0;
    wait_beats(b0 + 4);
    bus.avm_waitrequest = 1'b1; repeat (2) tick(); bus.avm_waitrequest = 1'b0;
    wait_idle("stall_idle", 200);
    chk("stall_beats", beats_seen - b0, 16);

    // FIFO underfill holds off the burst
    do_reset();
    push(8); wait_fill(8);
    wc0 = wr_cycles;
    go(32'h0000_3000, 32'd64, 2'b01, 1);
    repeat (10) tick();
    chk("uf_nowrite", wr_cycles - wc0, 0);
    push(8);
    k = 0;
    do begin @(negedge clk); k++; end while (int'(bus.fifo_usedw) < 16 && k < 50);
    chk("uf_write_early", bus.avm_write, 0);
    @(negedge clk);
    chk("uf_write_start", bus.avm_write, 1);
    push(48);
    wait_idle("uf_idle", 500);

    // loop mode, enable cleared during the second pass
    do_reset();
    push(24); wait_fill(24);
    b0 = beats_seen; d0 = done_cnt;
    add_xfer(32'h0000_5000, 32'd32);
    add_xfer(32'h0000_5000, 32'd32);
    go(32'h0000_5000, 32'd32, 2'b11, 0);
    wait_beats(b0 + 11);
    bus.control_en = 2'b10;
    wait_idle("loop_idle", 200);
    repeat (20) tick();
    chk("loop_beats", beats_seen - b0, 16);
    chk("loop_done", done_cnt - d0, 2);
    chk("loop_state", bus.control_state, 0);

    // length 3 and disabled go
    do_reset();
    push(16); wait_fill(16);
    d0 = done_cnt; wc0 = wr_cycles;
    go(32'h0000_6000, 32'd3, 2'b01, 0);
    repeat (3) tick();
    chk("len3_done", done_cnt - d0, 1);
    go(32'h0000_6000, 32'd64, 2'b00, 0);
    repeat (10) tick();
    chk("en0_state", bus.control_state, 0);
    chk("noact_writes", wr_cycles - wc0, 0);
    chk("en0_done", done_cnt - d0, 1);

    // go while busy is ignored
    do_reset();
    push(32);
    b0 = beats_seen;
    go(32'h0000_7000, 32'd128, 2'b01, 1);
    wait_beats(b0 + 4);
    go(32'h9000_0000, 32'd64, 2'b01, 0);
    wait_idle("busy_idle", 300);
    chk("busy_beats", beats_seen - b0, 32);

    // address wrap
    do_reset();
    push(32); wait_fill(32);
    b0 = beats_seen;
    go(32'hFFFF_FFC0, 32'd128, 2'b01, 1);
    wait_idle("wrap_idle", 200);
    chk("wrap_beats", beats_seen - b0, 32);

    // reset in the middle of a burst
    do_reset();
    push(16); wait_fill(16);
    b0 = beats_seen;
    go(32'h0000_8000, 32'd64, 2'b01, 1);
    wait_beats(b0 + 5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_write", bus.avm_write, 0);
    chk("mid_rst_state", bus.control_state, 0);
    chk("mid_rst_rdreq", bus.fifo_rdreq, 0);
    chk("mid_rst_addr", bus.avm_address, 0);
    chk("mid_rst_bcnt", bus.avm_burstcount, 0);

    // randomized transfers with random waitrequest and FIFO fill
    do_reset();
    for (int t = 0; t < 8; t++) begin
      wait_mode = 1;
      rlen = 32'($urandom_range(0, 300));
      rbase = $urandom;
      words = int'(rlen >> 2);
      b0 = beats_seen; d0 = done_cnt;
      go(rbase, rlen, 2'b01, 1);
      k = 0;
      while (k < words) begin
        if ($urandom_range(0, 2) != 0) begin push(1); k++; end
        tick();
      end
      wait_idle("rnd_idle", 3000);
      chk("rnd_beats", beats_seen - b0, words);
      chk("rnd_done", done_cnt - d0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_write_dma.md
# frame_write_dma

Avalon-MM write-master sequencer that executes the transfer programmed through the control register slave. On a `control_go` pulse it drains a show-ahead data FIFO into memory at `control_user_base` for `control_user_length` bytes using length-bounded bursts. It reports busy/done back to the register slave. It sits between the acquisition FIFO and the HPS/SDRAM Avalon-MM port.

## Interface
- `DATA_W`, 32: data width in bits; a beat is 4 bytes.
- `BURST_MAX`, 16: maximum beats per burst; must be a power of 2.
- `USEDW_W`, 9: FIFO fill-level width.
- `BC_W`, 5: burstcount width; must be at least log2(BURST_MAX)+1.

- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `control_go` in 1: single-cycle start pulse.
- `control_user_base` in 32: byte start address. Bits [1:0] are ignored.
- `control_user_length` in 32: transfer length in bytes. Bits [1:0] are ignored.
- `control_en` in 2: bit0 = enable, bit1 = continuous (loop) mode.
- `control_state` out 1: busy flag; 1 whenever the FSM is not in IDLE.
- `control_done` out 1: one-cycle pulse when a transfer completes.
- `fifo_q` in DATA_W: show-ahead FIFO head word.
- `fifo_usedw` in USEDW_W: FIFO fill level.
- `fifo_rdreq` out 1: pops the FIFO head.
- `avm_address` out 32: byte address of the burst.
- `avm_write` out 1: write request.
- `avm_writedata` out DATA_W: write data.
- `avm_burstcount` out BC_W: beats in the current burst.
- `avm_waitrequest` in 1: slave stall.

## Operation
- Word count: `words = control_user_length[31:2]`. Start address: `{control_user_base[31:2], 2'b00}`. Both are latched at go, along with `control_en[1]`.
- States: IDLE, WAIT_DATA, BURST.
- **IDLE**
  - `control_go & control_en[0] & words!=0`: latch base, words and loop bit; set addr = base and remaining = words; go to WAIT_DATA.
  - `control_go & control_en[0] & words==0`: pulse `control_done`; stay in IDLE.
  - Go with `control_en[0]=0`: ignored.
- **WAIT_DATA**
  - `bc = min(BURST_MAX, remaining)`.
  - If `control_en[0]==0`: abort to IDLE with no done pulse.
  - Else if `fifo_usedw >= bc`: load `avm_address=addr`, `avm_burstcount=bc`, beat counter = bc; assert `avm_write`; go to BURST.
- **BURST**
  - `avm_writedata = fifo_q`.
  - `fifo_rdreq = avm_write & ~avm_waitrequest` (combinational).
  - Each accepted beat decrements the beat counter and remaining.
  - `avm_address` and `avm_burstcount` stay constant for the whole burst.
  - A burst is never abandoned: clearing enable mid-burst takes effect only at the next WAIT_DATA.
- **End of burst** (last beat accepted)
  - Deassert `avm_write`; set addr += bc*4, modulo 2^32.
  - If remaining != 0: go to WAIT_DATA.
  - If remaining == 0: pulse `control_done`. If latched loop bit and `control_en[0]` are both set, reload addr and remaining from the latched values and go to WAIT_DATA; otherwise go to IDLE.
- Go while not in IDLE: ignored. The latched parameters are not modified.
- Reset values:
  - `control_state=0`, `control_done=0`, `avm_write=0`, `fifo_rdreq=0`.
  - `avm_address=0`, `avm_burstcount=0`.
  - `avm_writedata` follows `fifo_q` (don't-care).
  - FSM in IDLE.
- Reset mid-burst: the FSM returns to IDLE immediately. A truncated burst is acceptable only under system reset.

## Timing
- Go sampled at cycle 0 → `control_state=1` at cycle 1 (WAIT_DATA).
- With sufficient FIFO data, the first `avm_write` is asserted at cycle 2.
- With no waitrequest, an N-beat burst occupies N consecutive cycles.
- The next burst starts no earlier than 2 cycles after the last beat: one cycle in WAIT_DATA, then `avm_write`.
- Last beat of the transfer accepted at cycle k → `control_done=1` for cycle k+1 only, and `avm_write=0` at k+1.
- `control_state=0` from k+1, unless in loop mode.
- The zero-length done pulse occurs the cycle after go.
- Waitrequest high:
  - Address, burstcount and data are held.
  - `fifo_rdreq` is 0.
  - No counters change.

## Test plan
- **Single burst.** Base 0x2000_0000, length 64, en=01, FIFO usedw=64, no waitrequest → one burst, addr 0x2000_0000, burstcount 16, 16 beats with data matching FIFO order. Done pulse 1 cycle after the last beat; `control_state` 1→0.
- **Split bursts.** Length 100 (25 words), base 0x1000 → bursts (0x1000, 16) then (0x1040, 9); exactly 25 rdreq pulses; one done pulse.
- **Waitrequest stall.** Waitrequest high on beats 3–5 of a 16-beat burst → rdreq low and data/address stable while stalled; 16 beats total; correct data order.
- **FIFO underfill.** usedw held at 8 with bc=16 → no `avm_write`. Raising usedw to 16 → burst starts 1 cycle later.
- **Loop mode.** en=11, length 32 → done pulse, then a new burst at base again. Clearing en[0] mid-burst → burst completes, FSM goes to IDLE, no further writes.
- **Edge cases.**
  - Length 3 → done pulse, no writes.
  - Go with en=00 → no activity.
  - Go during busy → ignored.
  - Base 0xFFFF_FFC0, length 128 → second burst address wraps to 0x0000_0000.
  - Reset asserted mid-burst → all outputs at reset values on the next cycle.
